// File: rtl/full_adder_checker_if.sv
// Stimulus/response and result bundle between the full-adder test environment and its checker.
interface full_adder_checker_if #(
   parameter int CNT_W = 8
);
   logic             EN;
   logic             CLR;
   logic [2:0]       stim;
   logic             s;
   logic             c1;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_cnt;
   logic [2:0]       fail_vec;
   logic             fail_valid;
   logic             seq_err;

   modport master (
      output EN, CLR, stim, s, c1,
      input  busy, done, pass, err_cnt, fail_vec, fail_valid, seq_err
   );

   modport slave (
      input  EN, CLR, stim, s, c1,
      output busy, done, pass, err_cnt, fail_vec, fail_valid, seq_err
   );
endinterface

// File: rtl/full_adder_checker.sv
// Self-checking receiver for the 3-bit counter -> full adder chain; collects pass/fail statistics.
// Define CHECKER_SATURATE_EN to make err_cnt saturate instead of wrapping.
//
// state | meaning
// IDLE  | waiting for EN
// SYNC  | hunting for delayed stim == 0 (vector 0)
// CHECK | comparing one vector per enabled edge
// DONE  | run complete, results held until CLR or reset
module full_adder_checker #(
   parameter int N_VECT = 8,
   parameter int LAT    = 0,
   parameter int CNT_W  = 8
) (
   input logic                 clk,
   input logic                 Reset,
   full_adder_checker_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;

   localparam logic [7:0] VEC_LAST = 8'(N_VECT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       stim_d;
   logic [1:0]       golden;
   logic             mismatch;
   logic             sync_hit;
   logic             check_en;
   logic             last_vec;
   logic             seq_bad;
   logic [7:0]       vec_cnt;
   logic [2:0]       prev_stim;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] err_inc;
   logic [2:0]       fail_vec;
   logic             fail_valid;
   logic             seq_err;
   logic             busy;
   logic             done;
   logic             pass;

   // Stimulus is delayed to line up with the adder's response latency.
   generate
      if (LAT == 0) begin : g_nolat
         assign stim_d = bus.stim;
      end else begin : g_lat
         logic [2:0] pipe [LAT];
         always_ff @(posedge clk or negedge Reset) begin
            if (!Reset) begin
               for (int i = 0; i < LAT; i++) pipe[i] <= 3'd0;
            end else if (bus.CLR) begin
               for (int i = 0; i < LAT; i++) pipe[i] <= 3'd0;
            end else begin
               pipe[0] <= bus.stim;
               for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign stim_d = pipe[LAT-1];
      end
   endgenerate

   assign golden   = {1'b0, stim_d[0]} + {1'b0, stim_d[1]} + {1'b0, stim_d[2]};
   assign mismatch = ({bus.c1, bus.s} != golden);
   assign sync_hit = (state == SYNC) && bus.EN && (stim_d == 3'd0);
   assign check_en = sync_hit || ((state == CHECK) && bus.EN);
   assign last_vec = (vec_cnt == VEC_LAST);
   assign seq_bad  = (state == CHECK) && (stim_d != prev_stim + 3'd1);

`ifdef CHECKER_SATURATE_EN
   assign err_inc = (err_cnt == {CNT_W{1'b1}}) ? err_cnt : err_cnt + CNT_W'(1);
`else
   assign err_inc = err_cnt + CNT_W'(1);
`endif

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.EN) state_nxt = SYNC;
         SYNC:    if (sync_hit) state_nxt = last_vec ? DONE : CHECK;
         CHECK:   if (bus.EN && last_vec) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (bus.CLR) state_nxt = IDLE;
   end

   always_comb begin
      busy = (state == SYNC) || (state == CHECK);
      done = (state == DONE);
      pass = done && (err_cnt == '0) && !seq_err;
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         vec_cnt    <= 8'd0;
         prev_stim  <= 3'd0;
         err_cnt    <= '0;
         fail_vec   <= 3'd0;
         fail_valid <= 1'b0;
         seq_err    <= 1'b0;
      end else if (bus.CLR) begin
         vec_cnt    <= 8'd0;
         prev_stim  <= 3'd0;
         err_cnt    <= '0;
         fail_vec   <= 3'd0;
         fail_valid <= 1'b0;
         seq_err    <= 1'b0;
      end else if (check_en) begin
         vec_cnt   <= vec_cnt + 8'd1;
         prev_stim <= stim_d;
         if (mismatch) begin
            err_cnt <= err_inc;
            if (!fail_valid) begin
               fail_vec   <= stim_d;
               fail_valid <= 1'b1;
            end
         end
         if (seq_bad) seq_err <= 1'b1;
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.pass       = pass;
   assign bus.err_cnt    = err_cnt;
   assign bus.fail_vec   = fail_vec;
   assign bus.fail_valid = fail_valid;
   assign bus.seq_err    = seq_err;

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker: a counter/adder model drives the checker, expected run results are queued and compared at done.
module tb_full_adder_checker;

   logic clk = 1'b0;
   logic Reset;
   bit   s_stuck0;

   always #5 clk = ~clk;

   full_adder_checker_if #(.CNT_W(8)) bus ();
   full_adder_checker_if #(.CNT_W(2)) bus2 ();

   full_adder_checker #(.N_VECT(8), .LAT(0), .CNT_W(8)) dut (
      .clk(clk), .Reset(Reset), .bus(bus)
   );
   full_adder_checker #(.N_VECT(8), .LAT(0), .CNT_W(2)) dut2 (
      .clk(clk), .Reset(Reset), .bus(bus2)
   );

   // Reference adder (optionally with sum stuck at 0) and an always-wrong adder for the narrow counter.
   logic maj;
   assign maj    = (bus.stim[0] & bus.stim[1]) | (bus.stim[0] & bus.stim[2]) | (bus.stim[1] & bus.stim[2]);
   assign bus.s  = s_stuck0 ? 1'b0 : ^bus.stim;
   assign bus.c1 = maj;

   assign bus2.EN   = bus.EN;
   assign bus2.CLR  = bus.CLR;
   assign bus2.stim = bus.stim;
   assign bus2.s    = ~(^bus.stim);
   assign bus2.c1   = ~maj;

   typedef struct {
      int err_cnt;
      int fail_vec;
      int fail_valid;
      int seq_err;
      int pass;
      int cycles;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},       32'(bus.busy),       32'd0);
      chk({tag, "_done"},       32'(bus.done),       32'd0);
      chk({tag, "_pass"},       32'(bus.pass),       32'd0);
      chk({tag, "_err_cnt"},    32'(bus.err_cnt),    32'd0);
      chk({tag, "_fail_vec"},   32'(bus.fail_vec),   32'd0);
      chk({tag, "_fail_valid"}, 32'(bus.fail_valid), 32'd0);
      chk({tag, "_seq_err"},    32'(bus.seq_err),    32'd0);
   endtask

   task automatic do_clear(input string tag);
      @(negedge clk);
      bus.CLR = 1'b1;
      bus.EN  = 1'b1;
      bus.stim = 3'd0;
      @(negedge clk);
      bus.CLR = 1'b0;
      bus.EN  = 1'b0;
      check_zero(tag);
   endtask

   // Counter sweep from 0; n counts negedges until done is seen (16 for an uninterrupted run).
   task automatic run_sweep(input bit skip, input bit pause, input bit abort, output int n);
      logic [2:0] cur;
      int cnt3, cnt4;
      bit paused, fin;
      cur = 3'd0; cnt3 = 0; cnt4 = 0; paused = 1'b0; fin = 1'b0; n = 0;
      @(negedge clk);
      bus.EN   = 1'b1;
      bus.stim = cur;
      for (int i = 0; i < 80 && !fin; i++) begin
         @(negedge clk);
         n++;
         if (bus.done) begin
            fin = 1'b1;
         end else if (abort && cur == 3'd4 && cnt4 == 2) begin
            Reset = 1'b0;
            #1;
            check_zero("rst_mid");
            fin = 1'b1;
         end else begin
            if (pause && !paused && cur == 3'd3 && cnt3 == 2) begin
               paused = 1'b1;
               bus.EN = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  n++;
               end
               bus.EN = 1'b1;
            end
            cur = (skip && cur == 3'd3) ? 3'd5 : cur + 3'd1;
            bus.stim = cur;
            if (cur == 3'd3) cnt3++;
            if (cur == 3'd4) cnt4++;
         end
      end
   endtask

   task automatic check_result(input string tag, input int n);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_done"},       32'(bus.done),       32'd1);
         chk({tag, "_busy"},       32'(bus.busy),       32'd0);
         chk({tag, "_cycles"},     32'(n),              32'(e.cycles));
         chk({tag, "_pass"},       32'(bus.pass),       32'(e.pass));
         chk({tag, "_err_cnt"},    32'(bus.err_cnt),    32'(e.err_cnt));
         chk({tag, "_fail_vec"},   32'(bus.fail_vec),   32'(e.fail_vec));
         chk({tag, "_fail_valid"}, 32'(bus.fail_valid), 32'(e.fail_valid));
         chk({tag, "_seq_err"},    32'(bus.seq_err),    32'(e.seq_err));
      end
   endtask

   initial begin
      int n;
      Reset    = 1'b0;
      bus.EN   = 1'b0;
      bus.CLR  = 1'b0;
      bus.stim = 3'd0;
      s_stuck0 = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      Reset = 1'b1;

      // Correct adder, full sweep.
      sb.push_back('{err_cnt: 0, fail_vec: 0, fail_valid: 0, seq_err: 0, pass: 1, cycles: 16});
      run_sweep(1'b0, 1'b0, 1'b0, n);
      check_result("t1", n);

      // Narrow counter with every vector failing: 8 errors into a 2-bit counter.
      chk("t6_done",       32'(bus2.done),       32'd1);
      chk("t6_fail_vec",   32'(bus2.fail_vec),   32'd0);
      chk("t6_fail_valid", 32'(bus2.fail_valid), 32'd1);
`ifdef CHECKER_SATURATE_EN
      chk("t6_err_cnt",    32'(bus2.err_cnt),    32'd3);
      chk("t6_pass",       32'(bus2.pass),       32'd0);
`else
      chk("t6_err_cnt",    32'(bus2.err_cnt),    32'd0);
      chk("t6_pass",       32'(bus2.pass),       32'd1);
`endif

      // Sum stuck at 0: stim 1,2,4,7 mismatch.
      do_clear("clr1");
      s_stuck0 = 1'b1;
      sb.push_back('{err_cnt: 4, fail_vec: 1, fail_valid: 1, seq_err: 0, pass: 0, cycles: 16});
      run_sweep(1'b0, 1'b0, 1'b0, n);
      check_result("t2", n);
      s_stuck0 = 1'b0;

      // EN low for 5 cycles mid-check with the counter held.
      do_clear("clr2");
      sb.push_back('{err_cnt: 0, fail_vec: 0, fail_valid: 0, seq_err: 0, pass: 1, cycles: 21});
      run_sweep(1'b0, 1'b1, 1'b0, n);
      check_result("t3", n);

      // Counter skips 3 -> 5.
      do_clear("clr3");
      sb.push_back('{err_cnt: 0, fail_vec: 0, fail_valid: 0, seq_err: 1, pass: 0, cycles: 15});
      run_sweep(1'b1, 1'b0, 1'b0, n);
      check_result("t4", n);

      // Reset during vector 4, then a clean rerun.
      do_clear("clr4");
      run_sweep(1'b0, 1'b0, 1'b1, n);
      @(negedge clk);
      check_zero("rst_hold");
      Reset  = 1'b1;
      bus.EN = 1'b0;
      sb.push_back('{err_cnt: 0, fail_vec: 0, fail_valid: 0, seq_err: 0, pass: 1, cycles: 16});
      run_sweep(1'b0, 1'b0, 1'b0, n);
      check_result("t5", n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
